in_service_ctrl: RTL and testbench
==================================

IN_SERVICE_CTRL -- requirements
Module: in_service_ctrl

Interface
REQ-001 SHALL have parameter LEVELS, default 8, meaning number of interrupt levels (power of two, 4..32).
REQ-002 SHALL have parameter PTR_W, default 3, meaning level-index width, equal to log2(LEVELS).
REQ-003 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port interrupt  input  LEVELS  one-hot winning request, sampled with latch_in_service.
REQ-006 SHALL have port latch_in_service  input  1  first-INTA strobe; sets the ISR bit.
REQ-007 SHALL have port end_of_ack  input  1  last-INTA strobe; triggers auto-EOI.
REQ-008 SHALL have port eoi_cmd  input  1  EOI/rotate command strobe.
REQ-009 SHALL have port eoi_type  input  2  00 non-specific EOI, 01 specific EOI, 10 rotate on non-specific EOI, 11 set-priority (no clear).
REQ-010 SHALL have port eoi_level  input  PTR_W  level used by specific EOI and set-priority.
REQ-011 SHALL have port auto_eoi  input  1  auto-EOI mode enable.
REQ-012 SHALL have port auto_rotate  input  1  rotate on auto-EOI.
REQ-013 SHALL have port in_service_register  output  LEVELS  registered ISR.
REQ-014 SHALL have port highest_level_in_service  output  LEVELS  one-hot highest-priority ISR bit (zero if none).
REQ-015 SHALL have port priority_rotate  output  PTR_W  registered current lowest-priority level.
REQ-016 SHALL have port isr_any  output  1  OR of the effective (unmasked) ISR bits.

Function
REQ-017 SHALL rank priority as follows: level (priority_rotate+1) mod LEVELS is highest, descending cyclically to priority_rotate, which is lowest.
REQ-018 SHALL derive highest_level_in_service and isr_any combinationally from the registered ISR and priority_rotate, so both are valid in the same cycle as any register update.
REQ-019 SHALL compute next ISR = (ISR & ~clear) | (latch_in_service ? interrupt : 0), so that a clear and a set on the same edge both take effect and a set overrides a clear on the same bit.
REQ-020 SHALL, on latch_in_service, also register the set level into last_level (PTR_W).
REQ-021 SHALL have eoi_type 00 clear the bit given by highest_level_in_service; with an empty ISR it makes no change.
REQ-022 SHALL have eoi_type 01 clear bit eoi_level; if that bit is already clear, it makes no change.
REQ-023 SHALL have eoi_type 10 clear as for 00 and load the cleared level into priority_rotate; with an empty ISR, priority_rotate is unchanged.
REQ-024 SHALL have eoi_type 11 load eoi_level into priority_rotate and leave the ISR unchanged.
REQ-025 SHALL, on end_of_ack with auto_eoi=1, clear bit last_level and, if auto_rotate=1, load last_level into priority_rotate.
REQ-026 SHALL, when eoi_cmd and an auto-EOI occur on the same edge, apply the OR of both clear masks; a rotate from eoi_cmd takes precedence over an auto-rotate.
REQ-027 SHALL ignore end_of_ack when auto_eoi=0.
REQ-028 SHALL update every register one clock after the strobe, with no other latency.

Reset
REQ-029 SHALL, while reset_n=0, force in_service_register=0, last_level=0 and priority_rotate=LEVELS-1 (level 0 highest), regardless of clock.
REQ-030 SHALL, as a result, show highest_level_in_service=0 and isr_any=0 during reset.
REQ-031 SHALL take no action on any strobe asserted during reset, and SHALL take no action on it after release unless it is still asserted at a clock edge.

Configuration
REQ-032 SHALL use macro PIC_SPECIAL_MASK_EN to compile the special-mask-mode feature in or out.
REQ-033 SHALL, with PIC_SPECIAL_MASK_EN defined, add ports special_mask_mode (input, 1) and interrupt_mask (input, LEVELS); when special_mask_mode=1, masked ISR bits are excluded from highest_level_in_service, isr_any and non-specific EOI selection, but remain in in_service_register.
REQ-034 SHALL, without PIC_SPECIAL_MASK_EN, omit both ports and apply no masking.

Verification
REQ-035 SHALL cover: reset, then latch interrupt=8'h08 -> ISR=8'h08, highest=8'h08, isr_any=1.
REQ-036 SHALL cover: ISR=8'h0A with rotate=7, then eoi_type 00 -> ISR=8'h08; a second 00 -> ISR=8'h00; a third 00 -> no change.
REQ-037 SHALL cover: ISR=8'h81, then eoi_type 10 -> ISR=8'h80, rotate=0, highest=8'h80.
REQ-038 SHALL cover: eoi_type 11 with eoi_level=3 -> rotate=3, ISR unchanged, ISR=8'h11 gives highest=8'h10.
REQ-039 SHALL cover: auto_eoi=1, auto_rotate=1, latch 8'h20, then end_of_ack -> ISR=8'h00, rotate=5; same-edge latch 8'h04 plus eoi_type 01 level 2 -> ISR bit 2 set.
REQ-040 SHALL cover: with PIC_SPECIAL_MASK_EN defined, ISR=8'h06, mask=8'h02, smm=1 -> highest=8'h04; then eoi_type 00 -> ISR=8'h02.

Source files
------------

// File: rtl/in_service_ctrl_if.sv
// In-service controller bus: strobes and configuration in, ISR status out.
// With PIC_SPECIAL_MASK_EN defined the special-mask inputs are added.
interface in_service_ctrl_if #(
  parameter int LEVELS = 8,
  parameter int PTR_W  = 3
);
  logic [LEVELS-1:0] interrupt;
  logic              latch_in_service;
  logic              end_of_ack;
  logic              eoi_cmd;
  logic [1:0]        eoi_type;
  logic [PTR_W-1:0]  eoi_level;
  logic              auto_eoi;
  logic              auto_rotate;
`ifdef PIC_SPECIAL_MASK_EN
  logic              special_mask_mode;
  logic [LEVELS-1:0] interrupt_mask;
`endif
  logic [LEVELS-1:0] in_service_register;
  logic [LEVELS-1:0] highest_level_in_service;
  logic [PTR_W-1:0]  priority_rotate;
  logic              isr_any;

  // Driver side: issues strobes, observes status.
  modport master (
`ifdef PIC_SPECIAL_MASK_EN
    output special_mask_mode, interrupt_mask,
`endif
    output interrupt, latch_in_service, end_of_ack, eoi_cmd, eoi_type,
    output eoi_level, auto_eoi, auto_rotate,
    input  in_service_register, highest_level_in_service, priority_rotate, isr_any
  );

  // Controller side.
  modport slave (
`ifdef PIC_SPECIAL_MASK_EN
    input  special_mask_mode, interrupt_mask,
`endif
    input  interrupt, latch_in_service, end_of_ack, eoi_cmd, eoi_type,
    input  eoi_level, auto_eoi, auto_rotate,
    output in_service_register, highest_level_in_service, priority_rotate, isr_any
  );
endinterface

// File: rtl/in_service_ctrl.sv
// Interrupt in-service register with rotating priority, specific /
// non-specific EOI, set-priority and auto-EOI (optionally rotating).
// Optional feature macro: PIC_SPECIAL_MASK_EN (special mask mode; masked
// ISR bits are hidden from priority resolution but kept in the ISR).
module in_service_ctrl #(
  parameter int LEVELS = 8,
  parameter int PTR_W  = 3
) (
  input logic              clock,
  input logic              reset_n,
  in_service_ctrl_if.slave bus
);

  logic [LEVELS-1:0] r_isr;
  logic [PTR_W-1:0]  r_last;
  logic [PTR_W-1:0]  r_rot;

  logic [LEVELS-1:0] w_mask;
  logic [LEVELS-1:0] w_eff;
  logic [LEVELS-1:0] w_high_oh;
  logic [LEVELS-1:0] w_clear;
  logic [PTR_W-1:0]  w_high_idx;
  logic [PTR_W-1:0]  w_lat_idx;
  logic [PTR_W-1:0]  w_rot_next;
  logic              w_any;
  logic              w_eoi_rot;

`ifdef PIC_SPECIAL_MASK_EN
  assign w_mask = bus.special_mask_mode ? bus.interrupt_mask : '0;
`else
  assign w_mask = '0;
`endif

  assign w_eff     = r_isr & ~w_mask;
  assign w_any     = |w_eff;
  assign w_high_oh = w_any ? (LEVELS'(1) << w_high_idx) : '0;

  // Scan from the level just above the lowest-priority one, wrapping around.
  always_comb begin
    logic [PTR_W-1:0] v_idx;
    logic             v_found;
    v_found    = 1'b0;
    v_idx      = '0;
    w_high_idx = '0;
    for (int k = 1; k <= LEVELS; k++) begin
      v_idx = r_rot + PTR_W'(k);
      if (!v_found && w_eff[v_idx]) begin
        v_found    = 1'b1;
        w_high_idx = v_idx;
      end
    end
  end

  // One-hot to index for the level being latched.
  always_comb begin
    w_lat_idx = '0;
    for (int i = 0; i < LEVELS; i++) begin
      if (bus.interrupt[i]) w_lat_idx = w_lat_idx | PTR_W'(i);
    end
  end

  // Clear mask and rotate update; an EOI rotate beats an auto-EOI rotate.
  always_comb begin
    w_clear    = '0;
    w_rot_next = r_rot;
    w_eoi_rot  = 1'b0;
    if (bus.eoi_cmd) begin
      case (bus.eoi_type)
        2'b00: w_clear = w_high_oh;
        2'b01: w_clear = LEVELS'(1) << bus.eoi_level;
        2'b10: begin
          w_clear = w_high_oh;
          if (w_any) begin
            w_rot_next = w_high_idx;
            w_eoi_rot  = 1'b1;
          end
        end
        default: begin
          w_rot_next = bus.eoi_level;
          w_eoi_rot  = 1'b1;
        end
      endcase
    end
    if (bus.end_of_ack && bus.auto_eoi) begin
      w_clear = w_clear | (LEVELS'(1) << r_last);
      if (bus.auto_rotate && !w_eoi_rot) w_rot_next = r_last;
    end
  end

  // State registers; a set on the same edge overrides a clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_isr  <= '0;
      r_last <= '0;
      r_rot  <= PTR_W'(LEVELS - 1);
    end else begin
      r_isr <= (r_isr & ~w_clear) | (bus.latch_in_service ? bus.interrupt : '0);
      if (bus.latch_in_service) r_last <= w_lat_idx;
      r_rot <= w_rot_next;
    end
  end

  assign bus.in_service_register      = r_isr;
  assign bus.highest_level_in_service = w_high_oh;
  assign bus.priority_rotate          = r_rot;
  assign bus.isr_any                  = w_any;

endmodule

// File: tb/tb_in_service_ctrl.sv
// Bench for in_service_ctrl: directed scenarios plus randomized traffic
// checked against a level-by-level behavioural model.
module tb_in_service_ctrl;
  localparam int LEVELS = 8;
  localparam int PTR_W  = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [LEVELS-1:0] t_intr = '0;
  logic              t_lat = 1'b0, t_eoa = 1'b0, t_ec = 1'b0;
  logic [1:0]        t_et = '0;
  logic [PTR_W-1:0]  t_el = '0;
  logic              t_ae = 1'b0, t_ar = 1'b0;
  logic              t_smm = 1'b0;
  logic [LEVELS-1:0] t_mask = '0;

  int total = 0;
  int bad = 0;

  in_service_ctrl_if #(.LEVELS(LEVELS), .PTR_W(PTR_W)) u_if ();

  assign u_if.interrupt        = t_intr;
  assign u_if.latch_in_service = t_lat;
  assign u_if.end_of_ack       = t_eoa;
  assign u_if.eoi_cmd          = t_ec;
  assign u_if.eoi_type         = t_et;
  assign u_if.eoi_level        = t_el;
  assign u_if.auto_eoi         = t_ae;
  assign u_if.auto_rotate      = t_ar;
`ifdef PIC_SPECIAL_MASK_EN
  assign u_if.special_mask_mode = t_smm;
  assign u_if.interrupt_mask    = t_mask;
`endif

  in_service_ctrl #(.LEVELS(LEVELS), .PTR_W(PTR_W)) dut (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (u_if.slave)
  );

  // Behavioural model: one flag per level, lowest-priority level, last latched.
  int m_isr [LEVELS];
  int m_rot;
  int m_last;

  function automatic void m_reset();
    for (int i = 0; i < LEVELS; i++) m_isr[i] = 0;
    m_rot  = LEVELS - 1;
    m_last = 0;
  endfunction

  function automatic bit m_masked(int lvl);
`ifdef PIC_SPECIAL_MASK_EN
    return t_smm && t_mask[lvl];
`else
    return 1'b0;
`endif
  endfunction

  // Highest-priority visible level, or -1.
  function automatic int m_high();
    for (int k = 1; k <= LEVELS; k++) begin
      int lvl;
      lvl = (m_rot + k) % LEVELS;
      if (m_isr[lvl] != 0 && !m_masked(lvl)) return lvl;
    end
    return -1;
  endfunction

  function automatic logic [LEVELS-1:0] m_isr_vec();
    logic [LEVELS-1:0] v;
    v = '0;
    for (int i = 0; i < LEVELS; i++) if (m_isr[i] != 0) v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [LEVELS-1:0] m_high_vec();
    logic [LEVELS-1:0] v;
    int h;
    v = '0;
    h = m_high();
    if (h >= 0) v[h] = 1'b1;
    return v;
  endfunction

  function automatic void m_update();
    int clr [LEVELS];
    int h, rot_new;
    bit eoi_rot;
    for (int i = 0; i < LEVELS; i++) clr[i] = 0;
    h = m_high();
    rot_new = m_rot;
    eoi_rot = 1'b0;
    if (t_ec) begin
      if (t_et == 2'd0 && h >= 0) clr[h] = 1;
      if (t_et == 2'd1) clr[int'(t_el)] = 1;
      if (t_et == 2'd2 && h >= 0) begin clr[h] = 1; rot_new = h; eoi_rot = 1'b1; end
      if (t_et == 2'd3) begin rot_new = int'(t_el); eoi_rot = 1'b1; end
    end
    if (t_eoa && t_ae) begin
      clr[m_last] = 1;
      if (t_ar && !eoi_rot) rot_new = m_last;
    end
    for (int i = 0; i < LEVELS; i++)
      m_isr[i] = ((m_isr[i] != 0 && clr[i] == 0) || (t_lat && t_intr[i])) ? 1 : 0;
    if (t_lat)
      for (int i = 0; i < LEVELS; i++) if (t_intr[i]) m_last = i;
    m_rot = rot_new;
  endfunction

  // One clock: inputs already driven, sample #1 after the edge, drop strobes.
  task automatic tick();
    @(posedge clk);
    #1;
    m_update();
    t_lat = 1'b0; t_eoa = 1'b0; t_ec = 1'b0;
  endtask

  task automatic latch(input logic [LEVELS-1:0] v);
    t_intr = v; t_lat = 1'b1;
    tick();
  endtask

  task automatic eoi(input logic [1:0] et, input logic [PTR_W-1:0] el);
    t_ec = 1'b1; t_et = et; t_el = el;
    tick();
  endtask

  task automatic do_reset();
    t_lat = 1'b0; t_eoa = 1'b0; t_ec = 1'b0;
    t_ae = 1'b0; t_ar = 1'b0; t_smm = 1'b0; t_mask = '0;
    rst_n = 1'b0;
    #7;
    rst_n = 1'b1;
    m_reset();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    latch(8'h10);
    // Assert reset asynchronously with every strobe active.
    t_intr = 8'h08; t_lat = 1'b1; t_ec = 1'b1; t_et = 2'b11; t_el = 3'd2;
    t_eoa = 1'b1; t_ae = 1'b1; t_ar = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    total++; if (u_if.in_service_register !== 8'h00) begin bad++; $display("FAIL rst_isr_async got=%h exp=00", u_if.in_service_register); end
    repeat (3) @(posedge clk);
    #1;
    total++; if (u_if.in_service_register !== 8'h00) begin bad++; $display("FAIL rst_isr got=%h exp=00", u_if.in_service_register); end
    total++; if (u_if.priority_rotate !== 3'd7) begin bad++; $display("FAIL rst_rot got=%0d exp=7", u_if.priority_rotate); end
    total++; if (u_if.highest_level_in_service !== 8'h00) begin bad++; $display("FAIL rst_high got=%h exp=00", u_if.highest_level_in_service); end
    total++; if (u_if.isr_any !== 1'b0) begin bad++; $display("FAIL rst_any got=%b exp=0", u_if.isr_any); end
    t_lat = 1'b0; t_ec = 1'b0; t_eoa = 1'b0; t_ae = 1'b0; t_ar = 1'b0;
    #3 rst_n = 1'b1;
    m_reset();
    @(posedge clk); #1;
    total++; if (u_if.in_service_register !== 8'h00 || u_if.priority_rotate !== 3'd7) begin
      bad++; $display("FAIL rst_release isr=%h rot=%0d exp isr=00 rot=7", u_if.in_service_register, u_if.priority_rotate);
    end
    latch(8'h08);
    total++; if (u_if.in_service_register !== 8'h08) begin bad++; $display("FAIL latch_isr got=%h exp=08", u_if.in_service_register); end
    total++; if (u_if.highest_level_in_service !== 8'h08) begin bad++; $display("FAIL latch_high got=%h exp=08", u_if.highest_level_in_service); end
    total++; if (u_if.isr_any !== 1'b1) begin bad++; $display("FAIL latch_any got=%b exp=1", u_if.isr_any); end
  endtask

  task automatic test_nonspecific_eoi();
    do_reset();
    latch(8'h02);
    latch(8'h08);
    total++; if (u_if.in_service_register !== 8'h0A) begin bad++; $display("FAIL ns_setup got=%h exp=0a", u_if.in_service_register); end
    eoi(2'b00, 3'd0);
    total++; if (u_if.in_service_register !== 8'h08) begin bad++; $display("FAIL ns_eoi1 got=%h exp=08", u_if.in_service_register); end
    eoi(2'b00, 3'd0);
    total++; if (u_if.in_service_register !== 8'h00) begin bad++; $display("FAIL ns_eoi2 got=%h exp=00", u_if.in_service_register); end
    eoi(2'b00, 3'd0);
    total++; if (u_if.in_service_register !== 8'h00 || u_if.priority_rotate !== 3'd7) begin
      bad++; $display("FAIL ns_eoi_empty isr=%h rot=%0d exp isr=00 rot=7", u_if.in_service_register, u_if.priority_rotate);
    end
    latch(8'h40);
    eoi(2'b01, 3'd5);
    total++; if (u_if.in_service_register !== 8'h40) begin bad++; $display("FAIL spec_eoi_clear_bit got=%h exp=40", u_if.in_service_register); end
    eoi(2'b01, 3'd6);
    total++; if (u_if.in_service_register !== 8'h00) begin bad++; $display("FAIL spec_eoi got=%h exp=00", u_if.in_service_register); end
  endtask

  task automatic test_rotate_eoi();
    do_reset();
    latch(8'h01);
    latch(8'h80);
    eoi(2'b10, 3'd0);
    total++; if (u_if.in_service_register !== 8'h80) begin bad++; $display("FAIL rot_eoi_isr got=%h exp=80", u_if.in_service_register); end
    total++; if (u_if.priority_rotate !== 3'd0) begin bad++; $display("FAIL rot_eoi_rot got=%0d exp=0", u_if.priority_rotate); end
    total++; if (u_if.highest_level_in_service !== 8'h80) begin bad++; $display("FAIL rot_eoi_high got=%h exp=80", u_if.highest_level_in_service); end
    eoi(2'b10, 3'd0);
    eoi(2'b10, 3'd0);
    total++; if (u_if.priority_rotate !== 3'd7 || u_if.in_service_register !== 8'h00) begin
      bad++; $display("FAIL rot_eoi_empty rot=%0d isr=%h exp rot=7 isr=00", u_if.priority_rotate, u_if.in_service_register);
    end
  endtask

  task automatic test_set_priority();
    do_reset();
    eoi(2'b11, 3'd3);
    total++; if (u_if.priority_rotate !== 3'd3) begin bad++; $display("FAIL setpri_rot got=%0d exp=3", u_if.priority_rotate); end
    total++; if (u_if.in_service_register !== 8'h00) begin bad++; $display("FAIL setpri_isr got=%h exp=00", u_if.in_service_register); end
    latch(8'h01);
    latch(8'h10);
    total++; if (u_if.highest_level_in_service !== 8'h10) begin bad++; $display("FAIL setpri_high got=%h exp=10", u_if.highest_level_in_service); end
    eoi(2'b11, 3'd5);
    total++; if (u_if.in_service_register !== 8'h11 || u_if.highest_level_in_service !== 8'h01) begin
      bad++; $display("FAIL setpri2 isr=%h high=%h exp isr=11 high=01", u_if.in_service_register, u_if.highest_level_in_service);
    end
  endtask

  task automatic test_auto_eoi();
    do_reset();
    latch(8'h20);
    t_eoa = 1'b1;
    tick();
    total++; if (u_if.in_service_register !== 8'h20) begin bad++; $display("FAIL aeoi_off got=%h exp=20", u_if.in_service_register); end
    t_ae = 1'b1; t_ar = 1'b1;
    t_eoa = 1'b1;
    tick();
    total++; if (u_if.in_service_register !== 8'h00) begin bad++; $display("FAIL aeoi_isr got=%h exp=00", u_if.in_service_register); end
    total++; if (u_if.priority_rotate !== 3'd5) begin bad++; $display("FAIL aeoi_rot got=%0d exp=5", u_if.priority_rotate); end
    t_intr = 8'h04; t_lat = 1'b1; t_ec = 1'b1; t_et = 2'b01; t_el = 3'd2;
    tick();
    total++; if (u_if.in_service_register !== 8'h04) begin bad++; $display("FAIL set_over_clear got=%h exp=04", u_if.in_service_register); end
    // Same-edge auto-EOI and set-priority: EOI rotate wins.
    latch(8'h40);
    t_eoa = 1'b1; t_ec = 1'b1; t_et = 2'b11; t_el = 3'd1;
    tick();
    total++; if (u_if.priority_rotate !== 3'd1 || u_if.in_service_register !== 8'h04) begin
      bad++; $display("FAIL aeoi_vs_eoi rot=%0d isr=%h exp rot=1 isr=04", u_if.priority_rotate, u_if.in_service_register);
    end
    t_ae = 1'b0; t_ar = 1'b0;
  endtask

`ifdef PIC_SPECIAL_MASK_EN
  task automatic test_special_mask();
    do_reset();
    latch(8'h02);
    latch(8'h04);
    t_mask = 8'h02; t_smm = 1'b1;
    #1;
    total++; if (u_if.highest_level_in_service !== 8'h04) begin bad++; $display("FAIL smm_high got=%h exp=04", u_if.highest_level_in_service); end
    eoi(2'b00, 3'd0);
    total++; if (u_if.in_service_register !== 8'h02) begin bad++; $display("FAIL smm_eoi got=%h exp=02", u_if.in_service_register); end
    total++; if (u_if.isr_any !== 1'b0) begin bad++; $display("FAIL smm_any got=%b exp=0", u_if.isr_any); end
    t_smm = 1'b0; t_mask = '0;
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      t_intr = '0;
      t_intr[$urandom_range(LEVELS - 1, 0)] = 1'b1;
      t_lat = ($urandom_range(2, 0) == 0);
      t_eoa = ($urandom_range(3, 0) == 0);
      t_ec  = ($urandom_range(2, 0) == 0);
      t_et  = 2'($urandom_range(3, 0));
      t_el  = PTR_W'($urandom_range(LEVELS - 1, 0));
      if ($urandom_range(15, 0) == 0) begin
        t_ae = $urandom_range(1, 0) == 1;
        t_ar = $urandom_range(1, 0) == 1;
      end
`ifdef PIC_SPECIAL_MASK_EN
      t_smm  = $urandom_range(1, 0) == 1;
      t_mask = LEVELS'($urandom);
`endif
      tick();
      total++;
      if (u_if.in_service_register !== m_isr_vec() || u_if.priority_rotate !== PTR_W'(m_rot) ||
          u_if.highest_level_in_service !== m_high_vec() || u_if.isr_any !== (m_high() >= 0)) begin
        bad++;
        $display("FAIL rand_%0d isr=%h/%h rot=%0d/%0d high=%h/%h any=%b (got/exp)", n,
                 u_if.in_service_register, m_isr_vec(), u_if.priority_rotate, m_rot,
                 u_if.highest_level_in_service, m_high_vec(), u_if.isr_any);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    m_reset();
    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_nonspecific_eoi();
    test_rotate_eoi();
    test_set_priority();
    test_auto_eoi();
`ifdef PIC_SPECIAL_MASK_EN
    test_special_mask();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
